// File: rtl/dec_rr_arbiter.sv
// rtl/dec_rr_arbiter.sv - round-robin arbiter sharing one 3-to-8 select decoder
//
// Purpose: picks one of 8 requesters, holds its select and one-hot grant for
// the whole transaction, then rotates priority past the winner. A grant held
// MAX_HOLD cycles is forcibly released with a one-cycle timeout pulse.
//
// Ports:
//   i_clk      system clock, rising edge
//   i_rst_n    synchronous active-low reset
//   i_req      request vector, bit n = requester n
//   i_done     winner signals transaction complete (pulse or level)
//   i_opt      grant polarity: 0 = active-low one-hot, 1 = active-high one-hot
//   o_sel      registered index of current/last winner
//   o_grant    decoded one-hot grant, polarity per i_opt
//   o_busy     grant active
//   o_timeout  one-cycle pulse on forced release at MAX_HOLD

module dec_rr_arbiter #(
    parameter int MAX_HOLD = 255,
    parameter int CNT_W    = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_req,
    input  logic       i_done,
    input  logic       i_opt,
    output logic [2:0] o_sel,
    output logic [7:0] o_grant,
    output logic       o_busy,
    output logic       o_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);

    state_t           r_state, w_state_nxt;
    logic [2:0]       r_ptr, w_ptr_nxt;
    logic [2:0]       r_sel, w_sel_nxt;
    logic             r_busy, w_busy_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_timeout, w_timeout_nxt;

    logic             w_found;
    logic [2:0]       w_win;
    logic             w_release;
    logic             w_expire;
    logic [7:0]       w_onehot;

    // First set request bit searching from r_ptr upward; the 3-bit add wraps
    // naturally mod 8.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        for (int i = 0; i < 8; i++) begin
            if (!w_found && i_req[r_ptr + 3'(i)]) begin
                w_found = 1'b1;
                w_win   = r_ptr + 3'(i);
            end
        end
    end

    // Normal release (done or withdrawal) takes precedence over the hold
    // limit, so a coincident expiry does not raise the timeout pulse.
    assign w_release = i_done || !i_req[r_sel];
    assign w_expire  = (r_cnt == HOLD_LAST);

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_sel_nxt     = r_sel;
        w_busy_nxt    = r_busy;
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_sel_nxt   = w_win;
                    w_busy_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (r_cnt != HOLD_MAX) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
                if (w_release || w_expire) begin
                    w_busy_nxt    = 1'b0;
                    w_timeout_nxt = w_expire && !w_release;
                    w_state_nxt   = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                // Rotate priority to the requester just after the winner.
                w_ptr_nxt   = r_sel + 3'd1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_ptr     <= 3'd0;
            r_sel     <= 3'd0;
            r_busy    <= 1'b0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_sel     <= w_sel_nxt;
            r_busy    <= w_busy_nxt;
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    // Decoder is combinational so an i_opt change shows in the same cycle.
    assign w_onehot  = r_busy ? (8'd1 << r_sel) : 8'd0;
    assign o_grant   = i_opt ? w_onehot : ~w_onehot;
    assign o_sel     = r_sel;
    assign o_busy    = r_busy;
    assign o_timeout = r_timeout;

endmodule

// File: tb/tb_dec_rr_arbiter.sv
// tb/tb_dec_rr_arbiter.sv - self-checking bench for dec_rr_arbiter

module tb_dec_rr_arbiter;

    localparam int MAX_HOLD = 4;
    localparam int CNT_W    = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic       opt;
    logic [2:0] o_sel;
    logic [7:0] o_grant;
    logic       o_busy;
    logic       o_timeout;

    int total = 0;
    int bad   = 0;

    // Reference model: transaction view of the arbiter.
    // m_phase 0 = waiting, 1 = holding a grant, 2 = dead gap after a grant.
    int m_phase = 0;
    int m_ptr   = 0;
    int m_sel   = 0;
    int m_held  = 0;
    bit m_busy  = 0;
    bit m_to    = 0;

    dec_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_req     (req),
        .i_done    (done),
        .i_opt     (opt),
        .o_sel     (o_sel),
        .o_grant   (o_grant),
        .o_busy    (o_busy),
        .o_timeout (o_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_grant();
        logic [7:0] g;
        g = m_busy ? ~(8'd1 << m_sel) : 8'hFF;
        return opt ? ~g : g;
    endfunction

    task automatic model_step();
        bit quit, timed;
        if (!rst_n) begin
            m_phase = 0; m_ptr = 0; m_sel = 0; m_held = 0; m_busy = 0; m_to = 0;
        end else begin
            case (m_phase)
                0: begin
                    m_to = 0;
                    for (int i = 0; i < 8; i++) begin
                        if (m_phase == 0 && req[(m_ptr + i) % 8]) begin
                            m_sel   = (m_ptr + i) % 8;
                            m_busy  = 1;
                            m_held  = 1;
                            m_phase = 1;
                        end
                    end
                end
                1: begin
                    quit  = done || !req[m_sel];
                    timed = (m_held == MAX_HOLD);
                    if (quit || timed) begin
                        m_busy  = 0;
                        m_to    = timed && !quit;
                        m_phase = 2;
                    end else begin
                        m_held++;
                        m_to = 0;
                    end
                end
                default: begin
                    m_to    = 0;
                    m_ptr   = (m_sel + 1) % 8;
                    m_phase = 0;
                end
            endcase
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        chk("m_sel", 32'(o_sel), 32'(m_sel));
        chk("m_busy", 32'(o_busy), 32'(m_busy));
        chk("m_grant", 32'(o_grant), 32'(exp_grant()));
        chk("m_timeout", 32'(o_timeout), 32'(m_to));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = 8'h00; done = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int sels[$];
        int gaps[$];
        int low, gcyc, busy_cnt, to_cnt;
        bit prev_busy;
        bit b_arr[10];
        int s_arr[10];

        opt = 1'b0;
        do_reset();

        // Reset state and same-cycle polarity switch
        chk("rst_grant", 32'(o_grant), 32'h000000FF);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_sel", 32'(o_sel), 32'd0);
        chk("rst_to", 32'(o_timeout), 32'd0);
        opt = 1'b1;
        #1;
        chk("rst_grant_opt1", 32'(o_grant), 32'h00000000);
        opt = 1'b0;

        // Two requesters alternating, done in the 2nd grant cycle
        req = 8'b0010_0100;
        prev_busy = 0; low = 0; gcyc = 0;
        for (int n = 0; n < 40 && sels.size() < 3; n++) begin
            step();
            if (o_busy && !prev_busy) begin
                sels.push_back(int'(o_sel));
                if (sels.size() > 1) gaps.push_back(low);
                if (sels.size() == 1) chk("rr_grant0", 32'(o_grant), 32'h000000FB);
                if (sels.size() == 2) chk("rr_grant1", 32'(o_grant), 32'h000000DF);
                low = 0; gcyc = 0;
            end
            if (o_busy) gcyc++; else low++;
            done = (o_busy && gcyc == 2);
            prev_busy = o_busy;
        end
        done = 1'b0;
        chk("rr_count", 32'(sels.size()), 32'd3);
        if (sels.size() == 3) begin
            chk("rr_sel0", 32'(sels[0]), 32'd2);
            chk("rr_sel1", 32'(sels[1]), 32'd5);
            chk("rr_sel2", 32'(sels[2]), 32'd2);
        end
        foreach (gaps[i]) chk("rr_gap", 32'(gaps[i]), 32'd2);

        // All eight requesting, one-cycle grants
        do_reset();
        req = 8'hFF; done = 1'b1;
        sels.delete();
        prev_busy = 0;
        for (int n = 0; n < 60 && sels.size() < 9; n++) begin
            step();
            if (o_busy && !prev_busy) begin
                sels.push_back(int'(o_sel));
                if (o_sel == 3'd3) begin
                    opt = 1'b1;
                    #1;
                    chk("all_opt_grant", 32'(o_grant), 32'h00000008);
                    opt = 1'b0;
                end
            end
            prev_busy = o_busy;
        end
        done = 1'b0;
        chk("all_count", 32'(sels.size()), 32'd9);
        foreach (sels[i]) chk("all_seq", 32'(sels[i]), 32'(i % 8));

        // Hold limit: requester 7 never finishes
        do_reset();
        req = 8'h80;
        for (int n = 0; n < 10; n++) begin
            step();
            b_arr[n] = o_busy;
            s_arr[n] = int'(o_sel);
            if (n < 6 && o_busy) busy_cnt++;
            if (o_timeout) to_cnt++;
        end
        chk("to_busy_len", 32'(busy_cnt), 32'd4);
        chk("to_pulses", 32'(to_cnt), 32'd1);
        chk("to_regrant_busy", 32'(b_arr[6]), 32'd1);
        chk("to_regrant_sel", 32'(s_arr[6]), 32'd7);

        // Done coincides with the last allowed cycle: normal release
        do_reset();
        req = 8'h80;
        for (int n = 0; n < 4; n++) step();
        done = 1'b1;
        step();
        chk("edge_busy", 32'(o_busy), 32'd0);
        chk("edge_to", 32'(o_timeout), 32'd0);
        done = 1'b0;

        // Withdrawal mid-grant
        do_reset();
        req = 8'h10;
        step();
        chk("wd_sel", 32'(o_sel), 32'd4);
        step();
        req = 8'h00;
        step();
        chk("wd_busy", 32'(o_busy), 32'd0);
        chk("wd_to", 32'(o_timeout), 32'd0);

        // Reset during a grant clears the rotation pointer
        do_reset();
        req = 8'h04;
        step();
        done = 1'b1;
        step();
        done = 1'b0; req = 8'h40;
        step();
        step();
        chk("rg_sel6", 32'(o_sel), 32'd6);
        rst_n = 1'b0;
        step();
        chk("rg_busy", 32'(o_busy), 32'd0);
        chk("rg_grant", 32'(o_grant), 32'h000000FF);
        rst_n = 1'b1; req = 8'h12;
        step();
        chk("rg_ptr0", 32'(o_sel), 32'd1);

        // Randomized run against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) req = 8'($urandom);
            if ($urandom_range(0, 15) == 0) req = 8'h00;
            done  = ($urandom_range(0, 7) == 0);
            opt   = $urandom_range(0, 1) == 1;
            rst_n = ($urandom_range(0, 199) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dec_rr_arbiter.md
Name: dec_rr_arbiter

Overview:
- Round-robin arbiter that shares one 3-to-8 select decoder between 8 requesters.
- Samples a request vector and picks one winner. Holds the 3-bit select plus a one-hot grant for the winner's whole transaction, then rotates priority.
- Grant polarity is runtime-selectable, matching the team's decoder option: active-low by default, inverted by i_opt.
- Sits between requesting agents and the shared decoded resource, e.g. chip-selects or digit enables.

Parameters:
- MAX_HOLD, 255, maximum cycles a grant may be held before forced release (1..2^CNT_W-1).
- CNT_W, 8, width of the hold counter.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst_n  input  1  synchronous active-low reset.
- i_req  input  8  request vector, bit n = requester n.
- i_done  input  1  winner signals transaction complete (single-cycle pulse or level).
- i_opt  input  1  grant polarity: 0 = active-low one-hot, 1 = active-high one-hot.
- o_sel  output  3  registered index of current/last winner.
- o_grant  output  8  decoded one-hot grant, polarity per i_opt.
- o_busy  output  1  grant active.
- o_timeout  output  1  one-cycle pulse when a grant is forcibly released at MAX_HOLD.

Behaviour:
- Reset: i_rst_n sampled low at a rising edge produces the following state.
  - state=IDLE, ptr=0, o_sel=0, o_busy=0, hold counter=0, o_timeout=0.
  - o_grant=8'hFF when i_opt=0; 8'h00 when i_opt=1.
  - Reset mid-grant aborts immediately; no timeout pulse.
- State machine:
  - IDLE: if |i_req, choose the first set bit searching ptr, ptr+1, ... wrapping mod 8.
    - At that edge: o_sel<=winner, o_busy<=1, counter<=0, go GRANT.
    - If i_req==0, stay in IDLE. i_done in IDLE is ignored.
  - GRANT: counter increments each cycle, saturating at MAX_HOLD. Exit to RELEASE at the first edge where any of these holds:
    - (a) i_done=1;
    - (b) i_req[o_sel]=0 (requester withdrew);
    - (c) counter==MAX_HOLD-1, i.e. grant held MAX_HOLD cycles.
    - On (c) only, o_timeout=1 for exactly the following cycle.
    - If (a) or (b) coincides with (c), it is a normal release and o_timeout stays 0.
  - RELEASE: exactly one cycle.
    - o_busy=0 and grant deasserted.
    - ptr<=o_sel+1 (7 wraps to 0).
    - Go IDLE.
    - This guarantees a one-cycle dead gap between grants.
- Latency:
  - Request seen in IDLE at edge k makes o_busy/o_grant valid after edge k.
  - Minimum grant length is 1 cycle.
  - Minimum spacing between consecutive grants is 3 cycles: GRANT, RELEASE, IDLE.
- Registers and fixed behaviour:
  - Changes to other i_req bits during GRANT have no effect.
  - o_sel retains the last winner while idle.
- o_grant decoding is combinational from o_busy, o_sel and i_opt:
  - busy: bit o_sel = 0, others = 1; inverted if i_opt=1.
  - not busy: all 1 (i_opt=0) or all 0 (i_opt=1).
  - i_opt may change at any time; o_grant follows it in the same cycle, and the FSM is unaffected.
- Fairness: a continuously requesting agent waits at most 7 other grants.

Test Plan:
- Reset, i_opt=0, i_req=0 → o_grant=8'hFF, o_busy=0, o_sel=0; set i_opt=1 → o_grant=8'h00 the same cycle.
- i_req=8'b0010_0100 held, i_done pulsed 2 cycles after each grant:
  - first grant o_sel=2, o_grant=8'b1111_1011;
  - next grant o_sel=5, o_grant=8'b1101_1111;
  - next back to 2;
  - busy-low gap of 1 cycle plus IDLE between grants.
- All 8 requesting, i_done each grant → o_sel sequence 0,1,2,...,7,0; i_opt=1 mid-run gives o_grant=8'b0000_1000 when o_sel=3.
- MAX_HOLD=4, i_req=8'h80 held, no i_done → o_busy high exactly 4 cycles, o_timeout pulses once, then ptr=0 and re-grant to 7.
- MAX_HOLD=4 with i_done asserted on the 4th grant cycle → release with o_timeout=0.
- Requester withdrawal and reset:
  - i_req[o_sel] dropped mid-grant → release next edge, no timeout.
  - i_rst_n low during GRANT → next cycle o_busy=0, o_grant=8'hFF (i_opt=0), ptr=0.
